// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: forwarding select codes,
// FSM state encoding and the hardwired zero register.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;
  localparam fwd_sel_t FWD_WB  = 2'd3;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A writer matches a source only if it really writes and the source is not r0.
  function automatic logic reg_match(input logic wr, input logic [4:0] rd,
                                     input logic [4:0] src);
    return wr && (rd == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline buffers/decode stage and the hazard control unit.
// Optional HAZARD_PERF_EN adds the stall_cycles / kill_count counters.
interface hazard_ctrl_unit_if;
  import hazard_pkg::*;

  logic [4:0] Rs_D;
  logic [4:0] Rt_D;
  logic       UsesRs_D;
  logic       UsesRt_D;
  logic       Taken_D;
  logic [4:0] Rd_EX;
  logic       RegWr_EX;
  logic       MemRd_EX;
  logic [4:0] Rd_MEM;
  logic       RegWr_MEM;
  logic [4:0] Rd_WB;
  logic       RegWr_WB;

  fwd_sel_t   FwdA;
  fwd_sel_t   FwdB;
  logic       disable_IR;
  logic       disable_PC;
  logic       bubble_EX;
  logic       kill;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] kill_count;
`endif

  modport master (
    output Rs_D, Rt_D, UsesRs_D, UsesRt_D, Taken_D,
    output Rd_EX, RegWr_EX, MemRd_EX, Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB,
    input  FwdA, FwdB, disable_IR, disable_PC, bubble_EX, kill
`ifdef HAZARD_PERF_EN
    , input stall_cycles, kill_count
`endif
  );

  modport slave (
    input  Rs_D, Rt_D, UsesRs_D, UsesRt_D, Taken_D,
    input  Rd_EX, RegWr_EX, MemRd_EX, Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB,
    output FwdA, FwdB, disable_IR, disable_PC, bubble_EX, kill
`ifdef HAZARD_PERF_EN
    , output stall_cycles, kill_count
`endif
  );

endinterface

// File: rtl/fwd_select.sv
// Priority forwarding select for one decode operand: the youngest producer wins.
// A load sitting in EX has no data yet, so it is skipped at the EX level.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] rd_ex,
  input  logic       regwr_ex,
  input  logic       memrd_ex,
  input  logic [4:0] rd_mem,
  input  logic       regwr_mem,
  input  logic [4:0] rd_wb,
  input  logic       regwr_wb,
  output fwd_sel_t   sel
);

  // EX beats MEM beats WB; register file when nothing matches.
  always_comb begin
    sel = FWD_RF;
    if (reg_match(regwr_ex && !memrd_ex, rd_ex, src)) begin
      sel = FWD_EX;
    end else if (reg_match(regwr_mem, rd_mem, src)) begin
      sel = FWD_MEM;
    end else if (reg_match(regwr_wb, rd_wb, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit: operand forwarding selects, load-use stall sequencing
// (LOAD_STALL_CYCLES bubbles per hazard) and IF_ID flush on taken branches.
// Optional feature macro HAZARD_PERF_EN adds saturating stall/kill counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 3
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_unit_if.slave hz
);

  logic [0:0]       state;
  logic [0:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             run_st;
  logic             lu;
  logic             stall_now;
  logic             kill_now;

  fwd_select u_fwd_a (
    .src       (hz.Rs_D),
    .rd_ex     (hz.Rd_EX),
    .regwr_ex  (hz.RegWr_EX),
    .memrd_ex  (hz.MemRd_EX),
    .rd_mem    (hz.Rd_MEM),
    .regwr_mem (hz.RegWr_MEM),
    .rd_wb     (hz.Rd_WB),
    .regwr_wb  (hz.RegWr_WB),
    .sel       (fwd_a)
  );

  fwd_select u_fwd_b (
    .src       (hz.Rt_D),
    .rd_ex     (hz.Rd_EX),
    .regwr_ex  (hz.RegWr_EX),
    .memrd_ex  (hz.MemRd_EX),
    .rd_mem    (hz.Rd_MEM),
    .regwr_mem (hz.RegWr_MEM),
    .rd_wb     (hz.Rd_WB),
    .regwr_wb  (hz.RegWr_WB),
    .sel       (fwd_b)
  );

  // Load-use is only looked for in RUN; STALL holds regardless of inputs.
  assign run_st    = (state == ST_RUN);
  assign lu        = run_st && hz.RegWr_EX && hz.MemRd_EX && (hz.Rd_EX != REG_ZERO) &&
                     ((hz.UsesRs_D && (hz.Rs_D == hz.Rd_EX)) ||
                      (hz.UsesRt_D && (hz.Rt_D == hz.Rd_EX)));
  assign stall_now = lu || (state == ST_STALL);
  assign kill_now  = run_st && !lu && hz.Taken_D;

  // Every output is forced low while reset is held, including the combinational ones.
  assign hz.FwdA       = reset ? FWD_RF : fwd_a;
  assign hz.FwdB       = reset ? FWD_RF : fwd_b;
  assign hz.disable_IR = !reset && stall_now;
  assign hz.disable_PC = !reset && stall_now;
  assign hz.bubble_EX  = !reset && stall_now;
  assign hz.kill       = !reset && kill_now;

  // The detecting RUN cycle is bubble one; STALL covers the remaining ones.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (state == ST_RUN) begin
      if (lu && (LOAD_STALL_CYCLES > 1)) begin
        next_state = ST_STALL;
        next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 1);
      end
    end else begin
      if (cnt == CNT_W'(1)) begin
        next_state = ST_RUN;
        next_cnt   = '0;
      end else begin
        next_cnt = cnt - CNT_W'(1);
      end
    end
  end

  // State and down-counter registers; reset drops any stall in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] kill_count_q;

  // Saturating counts of PC-hold cycles and IF_ID flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      kill_count_q   <= '0;
    end else begin
      if (stall_now && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (kill_now && (kill_count_q != 32'hFFFF_FFFF)) begin
        kill_count_q <= kill_count_q + 32'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.kill_count   = kill_count_q;
`endif

endmodule
